// File: rtl/implication_queue_pkg.sv
// Shared types and sizing for the implication queue and its helpers.
package implication_queue_pkg;

    localparam int NUM_VARIABLE   = 128;
    localparam int VARIABLE_INDEX = $clog2(NUM_VARIABLE);
    localparam int QUEUE_DEPTH    = 16;
    localparam int PTR_W          = $clog2(QUEUE_DEPTH);

    // One unit-clause implication: which variable, and the polarity to assign it.
    typedef struct packed {
        logic [VARIABLE_INDEX-1:0] variable;
        logic                      value;
    } implication_t;

    function automatic implication_t make_implication(
        input logic [VARIABLE_INDEX-1:0] variable,
        input logic                      value
    );
        implication_t imp;
        imp.variable = variable;
        imp.value    = value;
        return imp;
    endfunction

endpackage

// File: rtl/implication_queue_if.sv
// Push side (from the clause evaluator) and pop side (to the assignment
// writer) of the implication queue. The queue itself is the slave.
interface implication_queue_if #(
    parameter int VARIABLE_INDEX = implication_queue_pkg::VARIABLE_INDEX
);
    logic                      in_unit;
    logic [VARIABLE_INDEX-1:0] in_variable;
    logic                      in_value;
    logic                      in_ready;

    logic                      out_valid;
    logic                      out_ready;
    logic [VARIABLE_INDEX-1:0] out_variable;
    logic                      out_value;

    modport master (
        output in_unit, in_variable, in_value, out_ready,
        input  in_ready, out_valid, out_variable, out_value
    );

    modport slave (
        input  in_unit, in_variable, in_value, out_ready,
        output in_ready, out_valid, out_variable, out_value
    );
endinterface

// File: rtl/implication_queue_pending_table.sv
// Per-variable record of implications currently sitting in the queue, used
// to drop duplicates and spot contradicting implications before enqueue.
module implication_pending_table #(
    parameter int NUM_VARIABLE   = implication_queue_pkg::NUM_VARIABLE,
    parameter int VARIABLE_INDEX = implication_queue_pkg::VARIABLE_INDEX
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clear_all,
    input  logic                      set_en,
    input  logic [VARIABLE_INDEX-1:0] set_variable,
    input  logic                      set_value,
    input  logic                      clr_en,
    input  logic [VARIABLE_INDEX-1:0] clr_variable,
    input  logic [VARIABLE_INDEX-1:0] lookup_variable,
    output logic                      lookup_hit,
    output logic                      lookup_value
);

    logic [NUM_VARIABLE-1:0] pending_q;
    logic [NUM_VARIABLE-1:0] value_q;

    // Set on enqueue, clear on dequeue; clear_all wipes every pending bit.
    // A set and a clear never target the same variable in one cycle, since
    // a variable is only set when it is not already pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            value_q   <= '0;
        end else if (clear_all) begin
            pending_q <= '0;
        end else begin
            if (clr_en) begin
                pending_q[clr_variable] <= 1'b0;
            end
            if (set_en) begin
                pending_q[set_variable] <= 1'b1;
                value_q[set_variable]   <= set_value;
            end
        end
    end

    assign lookup_hit   = pending_q[lookup_variable];
    assign lookup_value = value_q[lookup_variable];

endmodule

// File: rtl/implication_queue.sv
// Implication queue: classifies incoming unit-clause implications as new,
// duplicate or conflicting, buffers new ones in a FIFO, and hands them to the
// assignment writer one at a time.
module implication_queue
    import implication_queue_pkg::*;
#(
    parameter int NUM_VARIABLE   = implication_queue_pkg::NUM_VARIABLE,
    parameter int VARIABLE_INDEX = $clog2(NUM_VARIABLE),
    parameter int QUEUE_DEPTH    = implication_queue_pkg::QUEUE_DEPTH,
    parameter int PTR_W          = $clog2(QUEUE_DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    implication_queue_if.slave        bus,
    input  logic                      flush,
    output logic                      conflict,
    output logic [VARIABLE_INDEX-1:0] conflict_variable,
    output logic [PTR_W:0]            count,
    output logic                      dup_drop
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(QUEUE_DEPTH);

    implication_t              mem [QUEUE_DEPTH];
    implication_t              head;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W:0]            count_q;
    logic                      conflict_q;
    logic [VARIABLE_INDEX-1:0] conflict_variable_q;
    logic                      dup_drop_q;

    logic                      in_ready_w;
    logic                      out_valid_w;
    logic                      push_try;
    logic                      push_new;
    logic                      push_dup;
    logic                      push_conf;
    logic                      pop;
    logic                      hit;
    logic                      hit_value;
    logic                      not_empty;

    // Ready depends only on registered state, so the evaluator sees a short
    // path; a full queue refuses even when a pop frees a slot this cycle.
    assign not_empty   = (count_q != '0);
    assign in_ready_w  = (count_q != FULL_COUNT) && !conflict_q;
    assign out_valid_w = not_empty && !conflict_q;

    assign push_try  = bus.in_unit && in_ready_w;
    assign push_new  = push_try && !hit;
    assign push_dup  = push_try && hit && (hit_value == bus.in_value);
    assign push_conf = push_try && hit && (hit_value != bus.in_value);
    assign pop       = out_valid_w && bus.out_ready;

    // Lookup reflects the table before this cycle's pop, so a push matching
    // the head being popped is still classified as a duplicate or conflict.
    implication_pending_table #(
        .NUM_VARIABLE   (NUM_VARIABLE),
        .VARIABLE_INDEX (VARIABLE_INDEX)
    ) u_pending (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear_all       (flush),
        .set_en          (push_new && !flush),
        .set_variable    (bus.in_variable),
        .set_value       (bus.in_value),
        .clr_en          (pop && !flush),
        .clr_variable    (head.variable),
        .lookup_variable (bus.in_variable),
        .lookup_hit      (hit),
        .lookup_value    (hit_value)
    );

    // FIFO storage needs no reset; the head outputs are masked while empty.
    always_ff @(posedge clock) begin
        if (push_new && !flush) begin
            mem[wr_ptr_q] <= make_implication(bus.in_variable, bus.in_value);
        end
    end

    // Pointers and occupancy; flush overrides any push or pop this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_new) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_new, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky conflict and one-cycle duplicate pulse. The first conflicting
    // variable is kept; a new conflict cannot arrive while one is latched
    // because in_ready is low, and flush leaves the last variable visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q          <= 1'b0;
            conflict_variable_q <= '0;
            dup_drop_q          <= 1'b0;
        end else if (flush) begin
            conflict_q <= 1'b0;
            dup_drop_q <= 1'b0;
        end else begin
            dup_drop_q <= push_dup;
            if (push_conf && !conflict_q) begin
                conflict_q          <= 1'b1;
                conflict_variable_q <= bus.in_variable;
            end
        end
    end

    assign head             = mem[rd_ptr_q];
    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = out_valid_w;
    assign bus.out_variable = not_empty ? head.variable : '0;
    assign bus.out_value    = not_empty ? head.value : 1'b0;

    assign conflict          = conflict_q;
    assign conflict_variable = conflict_variable_q;
    assign count             = count_q;
    assign dup_drop          = dup_drop_q;

endmodule

// File: tb/tb_implication_queue.sv
// Bench for implication_queue: directed scenarios followed by random traffic,
// all compared against a queue-based model of the implication rules.
module tb_implication_queue;
    import implication_queue_pkg::*;

    logic                      clock;
    logic                      reset_n;
    logic                      flush;
    logic                      conflict;
    logic [VARIABLE_INDEX-1:0] conflict_variable;
    logic [PTR_W:0]            count;
    logic                      dup_drop;

    implication_queue_if iq_if ();

    implication_queue dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .bus               (iq_if.slave),
        .flush             (flush),
        .conflict          (conflict),
        .conflict_variable (conflict_variable),
        .count             (count),
        .dup_drop          (dup_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the queue holds the pending implications in order;
    // a variable is pending exactly when it appears in the queue.
    typedef struct {
        int v;
        bit val;
    } ent_t;

    ent_t m_q[$];
    bit   m_conf;
    int   m_cvar;
    bit   m_dup;

    task automatic model_reset();
        m_q.delete();
        m_conf = 0;
        m_cvar = 0;
        m_dup  = 0;
    endtask

    task automatic compare_all();
        int n;
        n = m_q.size();
        chk_val("out_valid", int'(iq_if.out_valid), int'(n != 0 && !m_conf));
        chk_val("out_variable", int'(iq_if.out_variable), (n != 0) ? m_q[0].v : 0);
        chk_val("out_value", int'(iq_if.out_value), (n != 0) ? int'(m_q[0].val) : 0);
        chk_val("count", int'(count), n);
        chk_val("in_ready", int'(iq_if.in_ready), int'(n != QUEUE_DEPTH && !m_conf));
        chk_val("conflict", int'(conflict), int'(m_conf));
        chk_val("conflict_variable", int'(conflict_variable), m_cvar);
        chk_val("dup_drop", int'(dup_drop), int'(m_dup));
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, then
    // compare just after the clock edge.
    task automatic step(input bit u, input int v, input bit val, input bit rdy, input bit fl);
        bit can_push, can_pop, found, fval, n_dup, do_push;
        iq_if.in_unit     = u;
        iq_if.in_variable = VARIABLE_INDEX'(v);
        iq_if.in_value    = val;
        iq_if.out_ready   = rdy;
        flush             = fl;

        can_push = (m_q.size() != QUEUE_DEPTH) && !m_conf;
        can_pop  = (m_q.size() != 0) && !m_conf;
        n_dup    = 0;
        do_push  = 0;
        found    = 0;
        fval     = 0;
        if (fl) begin
            m_q.delete();
            m_conf = 0;
        end else begin
            foreach (m_q[i]) begin
                if (m_q[i].v == v) begin
                    found = 1;
                    fval  = m_q[i].val;
                end
            end
            if (u && can_push) begin
                if (!found) begin
                    do_push = 1;
                end else if (fval == val) begin
                    n_dup = 1;
                end else begin
                    m_conf = 1;
                    m_cvar = v;
                end
            end
            if (can_pop && rdy) void'(m_q.pop_front());
            if (do_push) m_q.push_back('{v: v, val: val});
        end
        m_dup = n_dup;

        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, rdy, 0);
    endtask

    initial begin
        reset_n           = 1'b0;
        flush             = 1'b0;
        iq_if.in_unit     = 1'b0;
        iq_if.in_variable = '0;
        iq_if.in_value    = 1'b0;
        iq_if.out_ready   = 1'b0;
        model_reset();
        #12;
        compare_all();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        compare_all();

        // Single push and pop with one-cycle latency.
        step(1, 5, 1, 0, 0);
        chk_val("first_push_head", int'(iq_if.out_variable), 5);
        idle(1);

        // Duplicate of a pending implication is dropped with a pulse.
        step(1, 7, 0, 0, 0);
        step(1, 7, 0, 0, 0);
        chk_val("dup_pulse", int'(dup_drop), 1);
        idle(1);

        // Contradicting implication latches a conflict; flush recovers.
        step(1, 9, 1, 0, 0);
        step(1, 9, 0, 0, 0);
        chk_val("conflict_var9", int'(conflict_variable), 9);
        step(1, 11, 1, 1, 0);
        step(0, 0, 0, 1, 1);

        // Fill, reject a push on full even with a pop, then wrap the pointers.
        for (int i = 0; i < QUEUE_DEPTH; i++) step(1, 20 + i, bit'(i % 2), 0, 0);
        chk_val("full_count", int'(count), QUEUE_DEPTH);
        chk_val("full_in_ready", int'(iq_if.in_ready), 0);
        step(1, 40, 1, 1, 0);
        chk_val("full_push_rejected", int'(count), QUEUE_DEPTH - 1);
        for (int i = 0; i < 40; i++) step(1, 41 + i, bit'(i % 2), bit'(i % 3 != 0), 0);
        repeat (QUEUE_DEPTH + 2) idle(1);

        // Push matching the head being popped: duplicate, then conflict.
        step(0, 0, 0, 0, 1);
        step(1, 3, 1, 0, 0);
        step(1, 3, 1, 1, 0);
        chk_val("pop_dup_count", int'(count), 0);
        step(1, 3, 0, 0, 0);
        step(1, 3, 1, 1, 0);
        chk_val("pop_conflict", int'(conflict), 1);
        step(0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a cycle with entries queued.
        for (int i = 0; i < 4; i++) step(1, 60 + i, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        reset_n = 1'b1;
        step(1, 61, 1, 0, 0);
        step(1, 3, 1, 1, 0);
        idle(1);

        // Random traffic over a small variable range to provoke duplicates
        // and conflicts, with occasional flushes to clear them.
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 23)),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
